// File: rtl/seq_div32.sv
// Iterative restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional two's-complement support is compiled in with the DIV_SIGNED_EN macro.
module seq_div32 #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         signed_op,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_dvsr;

  logic          w_accept;
  logic          w_dvsr_zero;
  logic [N-1:0]  w_mag_a;
  logic [N-1:0]  w_mag_b;
  logic [N:0]    w_shift;
  logic [N:0]    w_trial;
  logic          w_ge;
  logic [N-1:0]  w_rem_nxt;
  logic [N-1:0]  w_quo_nxt;
  logic [N-1:0]  w_quo_fin;
  logic [N-1:0]  w_rem_fin;

  assign w_accept    = (r_state != CALC) && start;
  assign w_dvsr_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
  logic w_sgn_a;
  logic w_sgn_b;
  logic r_neg_q;
  logic r_neg_r;

  assign w_sgn_a   = signed_op & dividend[N-1];
  assign w_sgn_b   = signed_op & divisor[N-1];
  assign w_mag_a   = w_sgn_a ? (~dividend + 1'b1) : dividend;
  assign w_mag_b   = w_sgn_b ? (~divisor + 1'b1) : divisor;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign w_quo_fin = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
  assign w_rem_fin = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
`else
  logic w_unused_signed_op;

  assign w_unused_signed_op = signed_op;
  assign w_mag_a   = dividend;
  assign w_mag_b   = divisor;
  assign w_quo_fin = w_quo_nxt;
  assign w_rem_fin = w_rem_nxt;
`endif

  // The partial remainder stays below the divisor, so the MSB of the
  // (N+1)-bit trial difference is its sign.
  assign w_shift   = {r_rem, r_quo[N-1]};
  assign w_trial   = w_shift - {1'b0, r_dvsr};
  assign w_ge      = ~w_trial[N];
  assign w_rem_nxt = w_ge ? w_trial[N-1:0] : w_shift[N-1:0];
  assign w_quo_nxt = {r_quo[N-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = w_dvsr_zero ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_state_nxt = w_dvsr_zero ? DONE : CALC;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvsr      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt  <= CW'(N - 1);
      r_rem  <= '0;
      r_quo  <= w_mag_a;
      r_dvsr <= w_mag_b;
`ifdef DIV_SIGNED_EN
      r_neg_q <= w_sgn_a ^ w_sgn_b;
      r_neg_r <= w_sgn_a;
`endif
      if (w_dvsr_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (r_state == CALC) begin
      r_cnt <= r_cnt - 1'b1;
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      if (r_cnt == '0) begin
        quotient    <= w_quo_fin;
        remainder   <= w_rem_fin;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
